game_status_tracker: RTL and testbench

- Produces the status counters that the game-flow FSM consumes: lives lost, score, fruits resolved, and end-of-time.
- Turns raw per-pixel collision levels into at most one event per frame.
- Runs the frame-based countdown and a post-hit invulnerability window.
- Sits between the collision/drawing logic and the game-flow FSM. It also feeds the HUD digit drawers.

---
 rtl/game_status_pkg.sv | 22 ++
 rtl/frame_event_latch.sv | 24 ++
 rtl/game_status_tracker.sv | 168 ++++++++++++++++
 tb/tb_game_status_tracker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_status_pkg.sv
// Shared types and widths for the game status tracker.
package game_status_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_INVULN,
        S_FROZEN
    } state_t;

    localparam int LIVES_W   = 2;
    localparam int SCORE_W   = 4;
    localparam int FRUITS_W  = 4;
    localparam int SEC_W     = 7;
    localparam int LIVES_MAX = 3;
    localparam int SCORE_MAX = 15;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Turns a level input into at most one pulse per frame.
module frame_event_latch (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sof,
    input  logic level,
    output logic pulse
);

    logic flag;

    // A start-of-frame in the same cycle re-arms before the level is judged.
    assign pulse = en & level & (~flag | sof);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            flag <= 1'b0;
        end else begin
            flag <= level | (flag & ~sof);
        end
    end

endmodule

// File: rtl/game_status_tracker.sv
// Status counters, countdown and hit cooldown for the game-flow FSM.
// Define GAME_STATUS_BONUS_TIME_EN to add bonus seconds per eaten fruit.
module game_status_tracker
    import game_status_pkg::*;
#(
    parameter int FRAMES_PER_SEC      = 30,
    parameter int GAME_SECONDS        = 99,
    parameter int HIT_COOLDOWN_FRAMES = 30,
    parameter int FRUITS_MAX          = 10,
    parameter int BONUS_SECONDS       = 5
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                game_on,
    input  logic                fruit_eaten,
    input  logic                fruit_missed,
    input  logic                player_hit,
    output logic [LIVES_W-1:0]  livesCounter,
    output logic [SCORE_W-1:0]  scoreCounter,
    output logic [FRUITS_W-1:0] fruitsCounter,
    output logic                timer_end,
    output logic [SEC_W-1:0]    seconds_left,
    output logic                hit_flash
);

    localparam int FRM_W  = cnt_w(FRAMES_PER_SEC);
    localparam int COOL_W = cnt_w(HIT_COOLDOWN_FRAMES + 1);

    state_t             state;
    logic [FRM_W-1:0]   frame_cnt;
    logic [COOL_W-1:0]  cool;
    logic               active;
    logic               eat_p;
    logic               miss_p;
    logic               hit_p;
    logic               hit_cnt;
    logic               tick;
    logic               timer_set;
    logic [LIVES_W-1:0]  lives_nxt;
    logic [SCORE_W-1:0]  score_nxt;
    logic [FRUITS_W-1:0] fruits_nxt;
    logic [SEC_W-1:0]    sec_nxt;
    logic [FRM_W-1:0]    frame_nxt;
    int                  fsum;
    int                  ssum;

    assign active = (state == S_RUN) || (state == S_INVULN);

    frame_event_latch u_eat (
        .clk   (clk),
        .reset (resetN),
        .en    (active),
        .sof   (startOfFrame),
        .level (fruit_eaten),
        .pulse (eat_p)
    );

    frame_event_latch u_miss (
        .clk   (clk),
        .reset (resetN),
        .en    (active),
        .sof   (startOfFrame),
        .level (fruit_missed),
        .pulse (miss_p)
    );

    frame_event_latch u_hit (
        .clk   (clk),
        .reset (resetN),
        .en    (active),
        .sof   (startOfFrame),
        .level (player_hit),
        .pulse (hit_p)
    );

    always_comb begin
        hit_cnt    = hit_p && (state == S_RUN);
        lives_nxt  = livesCounter;
        score_nxt  = scoreCounter;
        fruits_nxt = fruitsCounter;
        if (hit_cnt && livesCounter != LIVES_W'(LIVES_MAX))
            lives_nxt = livesCounter + 1'b1;
        if (eat_p && scoreCounter != SCORE_W'(SCORE_MAX))
            score_nxt = scoreCounter + 1'b1;
        fsum = int'(fruitsCounter) + int'(eat_p) + int'(miss_p);
        if (fsum > FRUITS_MAX)
            fsum = FRUITS_MAX;
        fruits_nxt = FRUITS_W'(fsum);

        tick      = startOfFrame && frame_cnt == FRM_W'(FRAMES_PER_SEC - 1);
        frame_nxt = frame_cnt;
        if (startOfFrame)
            frame_nxt = tick ? '0 : frame_cnt + 1'b1;

        ssum = int'(seconds_left) - int'(tick);
`ifdef GAME_STATUS_BONUS_TIME_EN
        if (eat_p && !timer_end)
            ssum = ssum + BONUS_SECONDS;
`endif
        if (ssum < 0)
            ssum = 0;
        if (ssum > GAME_SECONDS)
            ssum = GAME_SECONDS;
        sec_nxt   = SEC_W'(ssum);
        timer_set = tick && (ssum == 0);
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state         <= S_IDLE;
            livesCounter  <= '0;
            scoreCounter  <= '0;
            fruitsCounter <= '0;
            timer_end     <= 1'b0;
            seconds_left  <= SEC_W'(GAME_SECONDS);
            hit_flash     <= 1'b0;
            frame_cnt     <= '0;
            cool          <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (game_on) begin
                        state         <= S_RUN;
                        livesCounter  <= '0;
                        scoreCounter  <= '0;
                        fruitsCounter <= '0;
                        timer_end     <= 1'b0;
                        seconds_left  <= SEC_W'(GAME_SECONDS);
                        hit_flash     <= 1'b0;
                        frame_cnt     <= '0;
                        cool          <= '0;
                    end
                end
                S_RUN, S_INVULN: begin
                    livesCounter  <= lives_nxt;
                    scoreCounter  <= score_nxt;
                    fruitsCounter <= fruits_nxt;
                    seconds_left  <= sec_nxt;
                    frame_cnt     <= frame_nxt;
                    timer_end     <= timer_set;
                    // Freezing outranks the cooldown entry; hit_flash keeps its value.
                    if (!game_on || timer_set ||
                        lives_nxt == LIVES_W'(LIVES_MAX)) begin
                        state <= S_FROZEN;
                    end else if (hit_cnt) begin
                        state     <= S_INVULN;
                        cool      <= COOL_W'(HIT_COOLDOWN_FRAMES);
                        hit_flash <= 1'b1;
                    end else if (state == S_INVULN && startOfFrame) begin
                        if (cool <= COOL_W'(1)) begin
                            state     <= S_RUN;
                            cool      <= '0;
                            hit_flash <= 1'b0;
                        end else begin
                            cool <= cool - 1'b1;
                        end
                    end
                end
                S_FROZEN: begin
                    state <= S_FROZEN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed, table-driven bench for game_status_tracker.
module tb_game_status_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sof, gon, fe, fm, ph;

    logic [1:0] lives, s_lives;
    logic [3:0] score, s_score;
    logic [3:0] fruits, s_fruits;
    logic       tend, s_tend;
    logic [6:0] sec, s_sec;
    logic       flash, s_flash;

    int checks = 0;
    int errors = 0;

    game_status_tracker u_dut (
        .clk           (clk),
        .resetN        (rst),
        .startOfFrame  (sof),
        .game_on       (gon),
        .fruit_eaten   (fe),
        .fruit_missed  (fm),
        .player_hit    (ph),
        .livesCounter  (lives),
        .scoreCounter  (score),
        .fruitsCounter (fruits),
        .timer_end     (tend),
        .seconds_left  (sec),
        .hit_flash     (flash)
    );

    game_status_tracker #(
        .FRAMES_PER_SEC (3),
        .GAME_SECONDS   (2)
    ) u_small (
        .clk           (clk),
        .resetN        (rst),
        .startOfFrame  (sof),
        .game_on       (gon),
        .fruit_eaten   (fe),
        .fruit_missed  (fm),
        .player_hit    (ph),
        .livesCounter  (s_lives),
        .scoreCounter  (s_score),
        .fruitsCounter (s_fruits),
        .timer_end     (s_tend),
        .seconds_left  (s_sec),
        .hit_flash     (s_flash)
    );

    logic [31:0] o_pack;
    assign o_pack = {13'd0, lives, score, fruits, tend, sec, flash};

    typedef struct {
        logic        rst, sof, gon, fe, fm, ph;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[23];

    function automatic logic [31:0] pk(input int l, input int sc,
                                       input int fr, input int te,
                                       input int se, input int fl);
        return {13'd0, 2'(l), 4'(sc), 4'(fr), 1'(te), 7'(se), 1'(fl)};
    endfunction

    function automatic vec_t v(input int r, input int s, input int g,
                               input int e, input int m, input int h,
                               input int l, input int sc, input int fr,
                               input int te, input int se, input int fl);
        vec_t x;
        x.rst = 1'(r);
        x.sof = 1'(s);
        x.gon = 1'(g);
        x.fe  = 1'(e);
        x.fm  = 1'(m);
        x.ph  = 1'(h);
        x.exp = pk(l, sc, fr, te, se, fl);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic m,
                       input logic h);
        sof = s;
        fe  = e;
        fm  = m;
        ph  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic h, input int len);
        cyc(1'b1, 1'b0, 1'b0, h);
        repeat (len - 1) cyc(1'b0, 1'b0, 1'b0, h);
        ph = 1'b0;
    endtask

    task automatic start_game();
        rst = 1'b1;
        gon = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gon = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        gon = 1'b0;
        sof = 1'b0;
        fe  = 1'b0;
        fm  = 1'b0;
        ph  = 1'b0;

        //        rst sof gon fe fm ph  lives score fruits tend sec flash
        vt[0]  = v(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 99, 0);
        vt[1]  = v(0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 99, 0);
        vt[2]  = v(0, 1, 1, 0, 1, 0,  0, 0, 1,  0, 99, 0);
        vt[3]  = v(0, 0, 1, 0, 1, 0,  0, 0, 1,  0, 99, 0);
        vt[4]  = v(0, 1, 1, 1, 1, 0,  0, 1, 3,  0, 99, 0);
        vt[5]  = v(0, 0, 1, 1, 1, 0,  0, 1, 3,  0, 99, 0);
        vt[6]  = v(0, 1, 1, 1, 1, 0,  0, 2, 5,  0, 99, 0);
        vt[7]  = v(0, 1, 1, 1, 1, 0,  0, 3, 7,  0, 99, 0);
        vt[8]  = v(0, 1, 1, 1, 1, 0,  0, 4, 9,  0, 99, 0);
        vt[9]  = v(0, 1, 1, 1, 1, 0,  0, 5, 10, 0, 99, 0);
        vt[10] = v(0, 1, 1, 1, 1, 0,  0, 6, 10, 0, 99, 0);
        vt[11] = v(0, 0, 1, 0, 0, 0,  0, 6, 10, 0, 99, 0);
        vt[12] = v(0, 0, 1, 0, 0, 0,  0, 6, 10, 0, 99, 0);
        vt[13] = v(0, 1, 1, 1, 0, 0,  0, 7, 10, 0, 99, 0);
        vt[14] = v(0, 0, 1, 1, 0, 0,  0, 7, 10, 0, 99, 0);
        vt[15] = v(0, 0, 1, 0, 0, 1,  1, 7, 10, 0, 99, 1);
        vt[16] = v(0, 0, 1, 0, 0, 1,  1, 7, 10, 0, 99, 1);
        vt[17] = v(0, 1, 1, 0, 0, 1,  1, 7, 10, 0, 99, 1);
        vt[18] = v(0, 0, 0, 0, 0, 0,  1, 7, 10, 0, 99, 1);
        vt[19] = v(0, 1, 0, 1, 1, 1,  1, 7, 10, 0, 99, 1);
        vt[20] = v(0, 1, 1, 1, 0, 1,  1, 7, 10, 0, 99, 1);
        vt[21] = v(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 99, 0);
        vt[22] = v(1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 99, 0);

        for (int i = 0; i < 23; i++) begin
            rst = vt[i].rst;
            gon = vt[i].gon;
            cyc(vt[i].sof, vt[i].fe, vt[i].fm, vt[i].ph);
            chk($sformatf("vec%0d", i), o_pack, vt[i].exp);
        end

        // Hit held through a long frame, then the cooldown window.
        start_game();
        frame(1'b1, 500);
        chk("hold_hit_lives", 32'(lives), 1);
        chk("hold_hit_flash", 32'(flash), 1);
        for (int f = 1; f < 30; f++) frame(1'b1, 4);
        chk("cooldown_lives", 32'(lives), 1);
        chk("cooldown_flash", 32'(flash), 1);
        frame(1'b0, 4);
        chk("cooldown_end_flash", 32'(flash), 0);
        frame(1'b1, 4);
        chk("frame31_hit", o_pack, pk(2, 0, 0, 0, 98, 1));

        // Three spaced hits freeze the game.
        start_game();
        frame(1'b1, 4);
        repeat (39) frame(1'b0, 4);
        frame(1'b1, 4);
        chk("second_hit", 32'(lives), 2);
        repeat (39) frame(1'b0, 4);
        frame(1'b1, 4);
        chk("third_hit", o_pack, pk(3, 0, 0, 0, 97, 0));
        repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frozen_hold", o_pack, pk(3, 0, 0, 0, 97, 0));

        // Countdown on the small instance.
        start_game();
        repeat (3) frame(1'b0, 4);
        chk("small_sec1", 32'({s_tend, s_sec}), 32'({1'b0, 7'd1}));
        repeat (2) frame(1'b0, 4);
        chk("small_sec1_hold", 32'({s_tend, s_sec}), 32'({1'b0, 7'd1}));
        frame(1'b0, 4);
        chk("small_end", 32'({s_tend, s_sec}), 32'({1'b1, 7'd0}));
        repeat (10) frame(1'b0, 4);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("small_end_hold", 32'({s_tend, s_sec, s_score}),
            32'({1'b1, 7'd0, 4'd0}));

        // Eaten fruit near the top of the countdown.
        start_game();
        repeat (60) frame(1'b0, 4);
        chk("sec97", 32'(sec), 97);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef GAME_STATUS_BONUS_TIME_EN
        chk("bonus_sat", o_pack, pk(0, 1, 1, 0, 99, 0));
`else
        chk("no_bonus", o_pack, pk(0, 1, 1, 0, 97, 0));
`endif
        gon = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef GAME_STATUS_BONUS_TIME_EN
        chk("drop_hold", o_pack, pk(0, 1, 1, 0, 99, 0));
`else
        chk("drop_hold", o_pack, pk(0, 1, 1, 0, 97, 0));
`endif
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_reset", o_pack, pk(0, 0, 0, 0, 99, 0));
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
